// File: rtl/clk_rate_monitor.sv
// Qualifies the measured clock-rate word against an expected window, debounces the result into a
// lock state machine and keeps loss, stopped-clock and min/max statistics.
module clk_rate_monitor #(
    parameter int unsigned EXPECTED_100HZ  = 400000,
    parameter int unsigned TOLERANCE_100HZ = 200,
    parameter int unsigned SAMPLE_PERIOD   = 10000000,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned LOSS_COUNT      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] rate_value,
    input  logic        sample_now,
    input  logic        clear_stats,
    output logic [1:0]  state,
    output logic        locked,
    output logic        in_range,
    output logic        stopped,
    output logic        lost_sticky,
    output logic [15:0] loss_count,
    output logic [31:0] rate_last,
    output logic [31:0] rate_min,
    output logic [31:0] rate_max
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StAcquire = 2'd1;
    localparam logic [1:0] StLocked  = 2'd2;
    localparam logic [1:0] StLost    = 2'd3;

    localparam int unsigned TimerW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TimerW-1:0] TimerLast = TimerW'(SAMPLE_PERIOD - 1);

    // Window bounds are evaluated at 33 bits so they clamp rather than wrap.
    localparam logic [32:0] ExpW   = 33'(EXPECTED_100HZ);
    localparam logic [32:0] TolW   = 33'(TOLERANCE_100HZ);
    localparam logic [32:0] MaxW   = 33'h0_FFFF_FFFF;
    localparam logic [32:0] LoW    = (ExpW >= TolW) ? (ExpW - TolW) : 33'd0;
    localparam logic [32:0] HiSum  = ExpW + TolW;
    localparam logic [32:0] HiW    = (HiSum > MaxW) ? MaxW : HiSum;
    localparam logic [8:0]  LockTh = 9'(LOCK_COUNT);
    localparam logic [8:0]  LossTh = 9'(LOSS_COUNT);

    logic [TimerW-1:0] timer_q, timer_d;
    logic [1:0]        state_q, state_d;
    logic [7:0]        good_q, good_d;
    logic [7:0]        bad_q, bad_d;
    logic              in_range_q, in_range_d;
    logic              stopped_q, stopped_d;
    logic              sticky_q, sticky_d;
    logic [15:0]       loss_cnt_q, loss_cnt_d;
    logic [31:0]       last_q, last_d;
    logic [31:0]       min_q, min_d;
    logic [31:0]       max_q, max_d;

    logic        timer_wrap;
    logic        tick;
    logic        sample_ok;
    logic        loss_event;
    logic [8:0]  good_inc;
    logic [8:0]  bad_inc;
    logic [31:0] min_base;
    logic [31:0] max_base;
    logic [15:0] cnt_base;

    assign timer_wrap = (timer_q == TimerLast);
    assign tick       = sample_now | timer_wrap;
    assign sample_ok  = ({1'b0, rate_value} >= LoW) && ({1'b0, rate_value} <= HiW);
    assign good_inc   = {1'b0, good_q} + 9'd1;
    assign bad_inc    = {1'b0, bad_q} + 9'd1;

    always_comb begin
        timer_d = timer_q + TimerW'(1);
        if (tick) begin
            timer_d = '0;
        end
    end

    // Lock FSM; only a tick can move it or its debounce counters.
    always_comb begin
        state_d    = state_q;
        good_d     = good_q;
        bad_d      = bad_q;
        loss_event = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle, StAcquire: begin
                    if (sample_ok) begin
                        if (good_inc >= LockTh) begin
                            state_d = StLocked;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            state_d = StAcquire;
                            good_d  = good_inc[7:0];
                        end
                    end else begin
                        state_d = StAcquire;
                        good_d  = '0;
                    end
                end
                StLocked: begin
                    if (sample_ok) begin
                        bad_d = '0;
                    end else if (bad_inc >= LossTh) begin
                        state_d    = StLost;
                        bad_d      = '0;
                        loss_event = 1'b1;
                    end else begin
                        bad_d = bad_inc[7:0];
                    end
                end
                default: begin
                    if (sample_ok) begin
                        if (LockTh == 9'd1) begin
                            state_d = StLocked;
                            bad_d   = '0;
                            good_d  = '0;
                        end else begin
                            state_d = StAcquire;
                            good_d  = 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    // A coincident clear is applied first, so the tick's sample and loss land on cleared stats.
    always_comb begin
        min_base   = clear_stats ? 32'hFFFF_FFFF : min_q;
        max_base   = clear_stats ? 32'h0000_0000 : max_q;
        cnt_base   = clear_stats ? 16'h0000 : loss_cnt_q;
        sticky_d   = clear_stats ? 1'b0 : sticky_q;
        min_d      = min_base;
        max_d      = max_base;
        loss_cnt_d = cnt_base;
        last_d     = last_q;
        in_range_d = in_range_q;
        stopped_d  = stopped_q;
        if (tick) begin
            last_d     = rate_value;
            in_range_d = sample_ok;
            stopped_d  = (rate_value == 32'd0);
            min_d      = (rate_value < min_base) ? rate_value : min_base;
            max_d      = (rate_value > max_base) ? rate_value : max_base;
        end
        if (loss_event) begin
            sticky_d = 1'b1;
            if (cnt_base != 16'hFFFF) begin
                loss_cnt_d = cnt_base + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q    <= '0;
            state_q    <= StIdle;
            good_q     <= '0;
            bad_q      <= '0;
            in_range_q <= 1'b0;
            stopped_q  <= 1'b0;
            sticky_q   <= 1'b0;
            loss_cnt_q <= '0;
            last_q     <= '0;
            min_q      <= 32'hFFFF_FFFF;
            max_q      <= '0;
        end else begin
            timer_q    <= timer_d;
            state_q    <= state_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            in_range_q <= in_range_d;
            stopped_q  <= stopped_d;
            sticky_q   <= sticky_d;
            loss_cnt_q <= loss_cnt_d;
            last_q     <= last_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    assign state       = state_q;
    assign locked      = (state_q == StLocked);
    assign in_range    = in_range_q;
    assign stopped     = stopped_q;
    assign lost_sticky = sticky_q;
    assign loss_count  = loss_cnt_q;
    assign rate_last   = last_q;
    assign rate_min    = min_q;
    assign rate_max    = max_q;

endmodule
